// File: rtl/picomips_pkg.sv
// Shared definitions for the picoMIPS control slice.
//   seq_state_t   : PC sequencer states (RUN, WAIT for button, HALT)
//   DB_CYCLES_DEF : default number of disagreeing synchronised samples
//                   needed before the debounced button level flips
package picomips_pkg;

  typedef enum logic [1:0] {
    S_RUN,
    S_WAIT,
    S_HALT
  } seq_state_t;

  localparam int DB_CYCLES_DEF = 4;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioning: two-flop synchroniser, counter debounce and
// rising-edge detect on the debounced level.
// Ports:
//   clk    in  system clock
//   reset  in  synchronous active-low reset
//   btn    in  raw asynchronous button, active-high
//   press  out one-cycle pulse on a debounced 0->1 transition
//   level  out debounced button level
// Parameters:
//   DB_CYCLES  consecutive disagreeing samples before the level flips (>=2)
//   CNT_W      counter width, 2**CNT_W > DB_CYCLES
module btn_debounce
  import picomips_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press,
  output logic level
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DB_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_db;
  logic             r_db_prev;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_db      <= 1'b0;
      r_db_prev <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_s1      <= btn;
      r_s2      <= r_s1;
      r_db_prev <= r_db;
      // Any sample agreeing with the current level restarts the count, so
      // a glitch shorter than DB_CYCLES never flips the level.
      if (r_s2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == LP_LAST) begin
        r_db  <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign press = r_db & ~r_db_prev;
  assign level = r_db;

endmodule

// File: rtl/pc_seq_ctrl.sv
// PC increment sequencer. Decodes the decoder's wait/halt qualifiers and
// gates the PC increment enable; WAIT holds the PC until a debounced
// button press arrives, HALT holds it until reset.
// Ports:
//   clk       in  system clock
//   reset     in  synchronous active-low reset; also gates all outputs low
//   wait_req  in  current instruction waits for a button press
//   halt_req  in  current instruction is HALT (priority over wait_req)
//   btn       in  raw asynchronous push button, active-high
//   PCincr    out PC increment enable (Mealy)
//   ack       out one-cycle pulse when a press releases WAIT
//   waiting   out state is WAIT
//   halted    out state is HALT
module pc_seq_ctrl
  import picomips_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic wait_req,
  input  logic halt_req,
  input  logic btn,
  output logic PCincr,
  output logic ack,
  output logic waiting,
  output logic halted
);

  seq_state_t r_state;
  seq_state_t w_next;
  logic       w_press;
  logic       w_level;
  logic       w_pcincr;
  logic       w_ack;

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_debounce (
    .clk   (clk),
    .reset (reset),
    .btn   (btn),
    .press (w_press),
    .level (w_level)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_next;
    end
  end

  // Presses seen outside WAIT are dropped here rather than queued.
  always_comb begin
    w_next   = r_state;
    w_pcincr = 1'b0;
    w_ack    = 1'b0;
    unique case (r_state)
      S_RUN: begin
        if (halt_req) begin
          w_next = S_HALT;
        end else if (wait_req) begin
          w_next = S_WAIT;
        end else begin
          w_pcincr = 1'b1;
        end
      end
      S_WAIT: begin
        if (w_press) begin
          w_pcincr = 1'b1;
          w_ack    = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_HALT: begin
        w_next = S_HALT;
      end
      default: begin
        w_next = S_RUN;
      end
    endcase
  end

  assign PCincr  = w_pcincr & reset;
  assign ack     = w_ack & reset;
  assign waiting = (r_state == S_WAIT) & reset;
  assign halted  = (r_state == S_HALT) & reset;

  // A press pulse can only exist while the debounced level is high.
  a_press_level : assert property (@(posedge clk) disable iff (!reset)
    w_press |-> w_level);

endmodule

// File: tb/tb_pc_seq_ctrl.sv
module tb_pc_seq_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic wait_req;
  logic halt_req;
  logic btn;
  logic PCincr;
  logic ack;
  logic waiting;
  logic halted;

  int checks = 0;
  int errors = 0;

  pc_seq_ctrl #(
    .DB_CYCLES (4),
    .CNT_W     (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wait_req (wait_req),
    .halt_req (halt_req),
    .btn      (btn),
    .PCincr   (PCincr),
    .ack      (ack),
    .waiting  (waiting),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  // Outputs packed as {PCincr, ack, waiting, halted}.
  function automatic logic [3:0] outs();
    return {PCincr, ack, waiting, halted};
  endfunction

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; wait_req = 1'b0; halt_req = 1'b0; btn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      after_edge();
      @(negedge clk);
      checks++;
      if (outs() !== 4'b0000) begin
        errors++;
        $display("FAIL reset_gate k=%0d got %b want 0000", k, outs());
      end
    end
    after_edge();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (outs() !== 4'b1000) begin
      errors++;
      $display("FAIL reset_release got %b want 1000", outs());
    end
  endtask

  task automatic test_run();
    for (int k = 0; k < 5; k++) begin
      after_edge();
      @(negedge clk);
      checks++;
      if (outs() !== 4'b1000) begin
        errors++;
        $display("FAIL run_step k=%0d got %b want 1000", k, outs());
      end
    end
  endtask

  // One RUN cycle with wait_req high; the following edge enters WAIT.
  task automatic enter_wait();
    after_edge();
    wait_req = 1'b1;
    @(negedge clk);
    checks++;
    if (outs() !== 4'b0000) begin
      errors++;
      $display("FAIL enter_wait got %b want 0000", outs());
    end
  endtask

  // In WAIT: button high for len cycles. A press (if any) is visible in
  // cycle 6 after the rise, then the sequencer runs with no requests.
  task automatic wait_pulse(input int len, input bit exp_press, input int ncyc);
    logic [3:0] exp;
    int         acks;
    acks = 0;
    for (int k = 0; k < ncyc; k++) begin
      after_edge();
      wait_req = 1'b0;
      btn = (k < len);
      @(negedge clk);
      if (exp_press) exp = {k >= 6, k == 6, k <= 6, 1'b0};
      else           exp = 4'b0010;
      if (ack) acks++;
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL pulse%0d k=%0d got %b want %b", len, k, outs(), exp);
      end
    end
    checks++;
    if (acks !== int'(exp_press)) begin
      errors++;
      $display("FAIL pulse%0d_ack_count got %0d want %0d", len, acks, int'(exp_press));
    end
  endtask

  task automatic test_wait_press();
    enter_wait();
    wait_pulse(10, 1'b1, 20);
  endtask

  task automatic test_glitch();
    enter_wait();
    wait_pulse(3, 1'b0, 16);
    // Exactly DB_CYCLES samples is the shortest pulse that counts.
    wait_pulse(4, 1'b1, 16);
  endtask

  task automatic test_halt();
    after_edge();
    halt_req = 1'b1; wait_req = 1'b1;
    @(negedge clk);
    checks++;
    if (outs() !== 4'b0000) begin
      errors++;
      $display("FAIL halt_enter got %b want 0000", outs());
    end
    for (int k = 0; k < 20; k++) begin
      after_edge();
      halt_req = 1'b0; wait_req = 1'b0;
      btn = (k < 10);
      @(negedge clk);
      checks++;
      if (outs() !== 4'b0001) begin
        errors++;
        $display("FAIL halt_hold k=%0d got %b want 0001", k, outs());
      end
    end
    after_edge();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (outs() !== 4'b0000) begin
      errors++;
      $display("FAIL halt_reset_gate got %b want 0000", outs());
    end
    after_edge();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (outs() !== 4'b1000) begin
      errors++;
      $display("FAIL halt_reset_run got %b want 1000", outs());
    end
  endtask

  // Press completes in RUN (dropped); wait_req arrives in the very cycle the
  // press pulse is high; only a release and second press releases WAIT.
  task automatic test_back_to_back();
    logic [3:0] exp;
    int         acks;
    acks = 0;
    for (int k = 0; k < 42; k++) begin
      after_edge();
      wait_req = (k == 6);
      btn = (k < 12) || (k >= 22 && k < 32);
      @(negedge clk);
      exp = {(k < 6) || (k >= 28), k == 28, (k >= 7) && (k <= 28), 1'b0};
      if (ack) acks++;
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL b2b k=%0d got %b want %b", k, outs(), exp);
      end
    end
    checks++;
    if (acks !== 1) begin
      errors++;
      $display("FAIL b2b_ack_count got %0d want 1", acks);
    end
  endtask

  task automatic test_reset_mid_wait();
    enter_wait();
    for (int k = 0; k < 7; k++) begin
      after_edge();
      wait_req = 1'b0;
      btn   = (k < 6);
      reset = !(k == 4 || k == 5);
      @(negedge clk);
      if (k == 4) begin
        checks++;
        if (dut.u_debounce.r_cnt !== 3'd2) begin
          errors++;
          $display("FAIL rst_mid_cnt_before got %0d want 2", dut.u_debounce.r_cnt);
        end
      end
      if (k == 5) begin
        checks++;
        if ({dut.u_debounce.r_cnt, dut.u_debounce.r_db} !== 4'b0000) begin
          errors++;
          $display("FAIL rst_mid_cleared got cnt=%0d db=%b want cnt=0 db=0",
                   dut.u_debounce.r_cnt, dut.u_debounce.r_db);
        end
      end
      if (k < 4)       exp_chk(k, 4'b0010);
      else if (k < 6)  exp_chk(k, 4'b0000);
      else             exp_chk(k, 4'b1000);
    end
  endtask

  task automatic exp_chk(input int k, input logic [3:0] exp);
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL rst_mid k=%0d got %b want %b", k, outs(), exp);
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_wait_press();
    test_glitch();
    test_halt();
    test_back_to_back();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_seq_ctrl.md
# pc_seq_ctrl

Sequencer feeding the program counter's increment enable (`PCincr`). It decodes the instruction flow qualifiers from the decoder: normal step, wait-for-user-input, and halt. While waiting it holds the PC until a debounced push-button press arrives. Sits directly upstream of the PC and between the board's raw button input and the decoder.

## Interface
- `DB_CYCLES`, default 4: consecutive synchronised samples that must disagree with the current debounced level before that level flips (≥2).
- `CNT_W`, default 3: debounce counter width; must satisfy 2^CNT_W > DB_CYCLES.

Ports:
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset (asserted when 0, sampled on rising `clk`).
- `wait_req`  in  1  decoder flag: the current instruction waits for a button press before the PC advances.
- `halt_req`  in  1  decoder flag: the current instruction is HALT.
- `btn`  in  1  raw asynchronous push button, active-high.
- `PCincr`  out  1  increment enable to the PC (combinational from state and inputs).
- `ack`  out  1  one-cycle pulse when a press releases a WAIT.
- `waiting`  out  1  high in state WAIT.
- `halted`  out  1  high in state HALT.

## Operation
- Button path:
  - Two-flop synchroniser `btn` → `s1` → `s2`.
  - Debounce counter `cnt` and debounced level `db`.
  - If `s2 == db`: `cnt <= 0`.
  - Else if `cnt == DB_CYCLES-1`: `db <= s2`, `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
  - `db_prev <= db`; `press = db & ~db_prev`, a one-cycle pulse.
- FSM states:
  - RUN:
    - `halt_req` → HALT with `PCincr=0`. Halt has priority over wait.
    - Else `wait_req` → WAIT with `PCincr=0`.
    - Else `PCincr=1` and stay in RUN.
    - Presses arriving in RUN are discarded and never queued.
  - WAIT:
    - `press` → `PCincr=1`, `ack=1`, next state RUN.
    - Otherwise hold with `PCincr=0`.
    - `wait_req` and `halt_req` are ignored while in WAIT.
  - HALT: `PCincr=0` permanently; leaving HALT requires reset.
- Simultaneous events:
  - A press in the same cycle as a RUN→WAIT transition is discarded. A fresh release-then-press is required.
  - A glitch shorter than `DB_CYCLES` synchronised cycles resets `cnt` and produces no press.
  - Release is debounced identically. A second press needs `db` to return to 0 first.

## Timing
- Reset (`reset==0` at a rising edge):
  - State RUN; `s1`, `s2`, `db`, `db_prev`, `cnt` all 0.
  - While reset is low: `PCincr=0`, `ack=0`, `waiting=0`, `halted=0`. These outputs are gated regardless of inputs.
- Reset mid-WAIT or mid-HALT returns to RUN on that edge. An in-progress debounce count is discarded.
- Press latency: `btn` rises before edge E1.
  - `s2=1` after E2.
  - `db=1` after edge E(2+DB_CYCLES).
  - `press`, `PCincr` and `ack` are high for the following cycle.
  - The PC advances at edge E(3+DB_CYCLES): E7 with the default.
- `waiting` and `halted` are registered state decodes. They assert the cycle after the transition edge.
- `PCincr` is a Mealy output. The PC registers it at the next rising edge, so there is no extra pipeline stage.

## Structure
- Shared package `picomips_pkg`:
  - `typedef enum logic [1:0] {S_RUN, S_WAIT, S_HALT} seq_state_t`.
  - Default debounce constant `DB_CYCLES_DEF = 4`.
- Sub-module `btn_debounce`:
  - Contains the synchroniser, counter, level and edge detect.
  - Ports: `clk`, `reset`, `btn`, `press`, `level`; parameters `DB_CYCLES`, `CNT_W`.
- Top level: FSM plus output decode only.

## Test plan
- Reset then `wait_req=halt_req=0` for 5 cycles → `PCincr=1` every cycle; `waiting=halted=0`.
- `wait_req=1` in RUN, then `btn=1` held 10 cycles:
  - `waiting=1` from the next cycle.
  - Exactly one `PCincr`/`ack` pulse, 7 cycles after `btn` rises (DB_CYCLES=4).
  - Back in RUN afterwards.
- In WAIT, `btn` pulses high for 3 cycles then low → no `press`, `PCincr` stays 0, remains in WAIT.
- `halt_req=1` and `wait_req=1` in the same RUN cycle:
  - Enters HALT; `halted=1`.
  - A later 10-cycle `btn` press gives `PCincr=0`.
  - Reset low for 1 edge → RUN with `PCincr=1`.
- Press completed while in RUN, `btn` still held, then `wait_req=1` → stays in WAIT until `btn` is released ≥4 cycles and pressed again; `ack` occurs only after the second press.
- `reset=0` asserted while WAIT with the debounce count at 2 → next cycle in RUN with `cnt=0`, `db=0`, and all outputs 0 while reset is held.
